// File: rtl/hssi_rst_seq_csr_if.sv
// rtl/hssi_rst_seq_csr_if.sv - decoded CSR strobe bus between the HSSI wrapper and the reset sequencer
interface hssi_rst_seq_csr_if #(
  parameter int ADDR_WIDTH = 11
);
  logic                  csr_write;
  logic [ADDR_WIDTH-1:0] csr_waddr;
  logic [63:0]           csr_wdata;
  logic                  csr_read;
  logic [ADDR_WIDTH-1:0] csr_raddr;
  logic [63:0]           csr_readdata;
  logic                  csr_readdata_valid;

  modport master (
    output csr_write, csr_waddr, csr_wdata, csr_read, csr_raddr,
    input  csr_readdata, csr_readdata_valid
  );

  modport slave (
    input  csr_write, csr_waddr, csr_wdata, csr_read, csr_raddr,
    output csr_readdata, csr_readdata_valid
  );
endinterface

// File: rtl/hssi_rst_seq_csr.sv
// rtl/hssi_rst_seq_csr.sv - per-channel HSSI reset sequencer with its own 64-bit CSR bank
// Each channel walks IDLE -> WAIT_ACK -> WAIT_RDY -> IDLE with a shared programmable timeout.
module hssi_rst_seq_csr #(
  parameter int               NUM_CH      = 16,
  parameter int               ADDR_WIDTH  = 11,
  parameter int               TMO_W       = 20,
  parameter logic [TMO_W-1:0] TMO_DEFAULT = 20'hF_FFFF
) (
  input  logic                clk,
  input  logic                rst,
  hssi_rst_seq_csr_if.slave   csr,
  output logic [NUM_CH-1:0]   o_tx_rst,
  output logic [NUM_CH-1:0]   o_rx_rst,
  output logic [NUM_CH-1:0]   o_axis_tx_areset,
  output logic [NUM_CH-1:0]   o_axis_rx_areset,
  input  logic [NUM_CH-1:0]   i_tx_rst_ack,
  input  logic [NUM_CH-1:0]   i_rx_rst_ack,
  input  logic [NUM_CH-1:0]   i_rx_pcs_ready
);

  localparam int IW = ADDR_WIDTH - 3;
  localparam logic [IW-1:0] R_RST_REQ = IW'(0);
  localparam logic [IW-1:0] R_BUSY    = IW'(1);
  localparam logic [IW-1:0] R_DONE    = IW'(2);
  localparam logic [IW-1:0] R_TMO_ERR = IW'(3);
  localparam logic [IW-1:0] R_LIMIT   = IW'(4);
  localparam logic [IW-1:0] R_SCRATCH = IW'(5);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_WAIT_RDY = 2'd2
  } ch_state_e;

  ch_state_e          state_q [NUM_CH];
  logic [TMO_W-1:0]   cnt_q   [NUM_CH];
  logic [NUM_CH-1:0]  tx_rst_q, rx_rst_q, axis_tx_q, axis_rx_q;

  logic [NUM_CH-1:0]  done_q, done_d;
  logic [NUM_CH-1:0]  tmo_q, tmo_d;
  logic [NUM_CH-1:0]  tmo_rdy_q, tmo_rdy_d;
  logic [TMO_W-1:0]   limit_q, limit_d;
  logic [63:0]        scratch_q, scratch_d;
  logic [63:0]        rd_data_q;
  logic               rd_valid_q;
  logic [63:0]        rd_word;

  logic [IW-1:0]      wr_idx, rd_idx;
  logic               wr_req, wr_done, wr_tmo, wr_limit, wr_scratch;
  logic [NUM_CH-1:0]  start, ack_exit, rdy_exit, tmo_hit, in_rdy, busy;
  logic               unused_addr_lsbs;

  assign wr_idx     = csr.csr_waddr[ADDR_WIDTH-1:3];
  assign rd_idx     = csr.csr_raddr[ADDR_WIDTH-1:3];
  assign wr_req     = csr.csr_write && (wr_idx == R_RST_REQ);
  assign wr_done    = csr.csr_write && (wr_idx == R_DONE);
  assign wr_tmo     = csr.csr_write && (wr_idx == R_TMO_ERR);
  assign wr_limit   = csr.csr_write && (wr_idx == R_LIMIT);
  assign wr_scratch = csr.csr_write && (wr_idx == R_SCRATCH);
  assign unused_addr_lsbs = ^{csr.csr_waddr[2:0], csr.csr_raddr[2:0]};

  // Exit conditions take priority over a timeout landing in the same cycle.
  always_comb begin
    start    = '0;
    ack_exit = '0;
    rdy_exit = '0;
    tmo_hit  = '0;
    in_rdy   = '0;
    busy     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      busy[c]     = (state_q[c] != ST_IDLE);
      in_rdy[c]   = (state_q[c] == ST_WAIT_RDY);
      start[c]    = wr_req && csr.csr_wdata[c] && (state_q[c] == ST_IDLE);
      ack_exit[c] = (state_q[c] == ST_WAIT_ACK) && i_tx_rst_ack[c] && i_rx_rst_ack[c];
      rdy_exit[c] = in_rdy[c] && i_rx_pcs_ready[c];
      tmo_hit[c]  = busy[c] && (limit_q != '0) && (cnt_q[c] >= limit_q)
                    && !ack_exit[c] && !rdy_exit[c];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= ST_IDLE;
        cnt_q[c]   <= '0;
      end
      tx_rst_q  <= '0;
      rx_rst_q  <= '0;
      axis_tx_q <= '0;
      axis_rx_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        case (state_q[c])
          ST_IDLE: begin
            if (start[c]) begin
              state_q[c]   <= ST_WAIT_ACK;
              cnt_q[c]     <= '0;
              tx_rst_q[c]  <= 1'b1;
              rx_rst_q[c]  <= 1'b1;
              axis_tx_q[c] <= 1'b1;
              axis_rx_q[c] <= 1'b1;
            end
          end
          ST_WAIT_ACK, ST_WAIT_RDY: begin
            if (ack_exit[c]) begin
              state_q[c]  <= ST_WAIT_RDY;
              cnt_q[c]    <= '0;
              tx_rst_q[c] <= 1'b0;
              rx_rst_q[c] <= 1'b0;
            end else if (rdy_exit[c] || tmo_hit[c]) begin
              state_q[c]   <= ST_IDLE;
              cnt_q[c]     <= '0;
              tx_rst_q[c]  <= 1'b0;
              rx_rst_q[c]  <= 1'b0;
              axis_tx_q[c] <= 1'b0;
              axis_rx_q[c] <= 1'b0;
            end else if (cnt_q[c] != '1) begin
              cnt_q[c] <= cnt_q[c] + TMO_W'(1);
            end
          end
          default: begin
            state_q[c]   <= ST_IDLE;
            cnt_q[c]     <= '0;
            tx_rst_q[c]  <= 1'b0;
            rx_rst_q[c]  <= 1'b0;
            axis_tx_q[c] <= 1'b0;
            axis_rx_q[c] <= 1'b0;
          end
        endcase
      end
    end
  end

  // Sticky status: a hardware set in the same cycle as a W1C clear wins.
  always_comb begin
    done_d    = done_q;
    tmo_d     = tmo_q;
    tmo_rdy_d = tmo_rdy_q;
    limit_d   = limit_q;
    scratch_d = scratch_q;
    if (wr_done) done_d = done_d & ~csr.csr_wdata[NUM_CH-1:0];
    if (wr_tmo) begin
      tmo_d     = tmo_d & ~csr.csr_wdata[NUM_CH-1:0];
      tmo_rdy_d = tmo_rdy_d & ~csr.csr_wdata[32 +: NUM_CH];
    end
    if (wr_limit)   limit_d   = csr.csr_wdata[TMO_W-1:0];
    if (wr_scratch) scratch_d = csr.csr_wdata;
    done_d    = done_d | rdy_exit;
    tmo_d     = tmo_d | tmo_hit;
    tmo_rdy_d = (tmo_rdy_d & ~tmo_hit) | (tmo_hit & in_rdy);
  end

  always_comb begin
    rd_word = '0;
    case (rd_idx)
      R_BUSY:    rd_word[NUM_CH-1:0] = busy;
      R_DONE:    rd_word[NUM_CH-1:0] = done_q;
      R_TMO_ERR: begin
        rd_word[NUM_CH-1:0]  = tmo_q;
        rd_word[32 +: NUM_CH] = tmo_rdy_q;
      end
      R_LIMIT:   rd_word[TMO_W-1:0] = limit_q;
      R_SCRATCH: rd_word = scratch_q;
      default:   rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q     <= '0;
      tmo_q      <= '0;
      tmo_rdy_q  <= '0;
      limit_q    <= TMO_DEFAULT;
      scratch_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      done_q     <= done_d;
      tmo_q      <= tmo_d;
      tmo_rdy_q  <= tmo_rdy_d;
      limit_q    <= limit_d;
      scratch_q  <= scratch_d;
      rd_valid_q <= csr.csr_read;
      rd_data_q  <= csr.csr_read ? rd_word : '0;
    end
  end

  assign csr.csr_readdata       = rd_data_q;
  assign csr.csr_readdata_valid = rd_valid_q;
  assign o_tx_rst         = tx_rst_q;
  assign o_rx_rst         = rx_rst_q;
  assign o_axis_tx_areset = axis_tx_q;
  assign o_axis_rx_areset = axis_rx_q;

endmodule
